perf_sample_reporter: RTL and testbench
=======================================

Name: perf_sample_reporter

Overview:
- Producer side of the FLOP/byte sample stream consumed by the arithmetic-intensity estimator.
- Observes SIMD ALU issue events and memory request handshakes inside a shader core.
- Accumulates FLOPs and bytes over a fixed cycle window, then emits one registered sample (flop_inc, byte_inc, valid) per window.
- Sits between the core's issue/memory front-end and the intensity estimator.

Parameters:
- LANES, 32, SIMD lanes per ALU issue (popcount width of alu_mask).
- WINDOW, 256, ACCUM cycles per sample; legal range 2..65536.
- CNT_W, 32, accumulator and output width. Production value is 32; benches may reduce it for saturation tests.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- enable  input  1  sampling enable
- alu_issue  input  1  ALU instruction issued this cycle
- alu_mask  input  LANES  active-lane mask of the issued instruction
- alu_fma  input  1  issued instruction is FMA (2 FLOPs per lane)
- mem_valid  input  1  memory request valid
- mem_ready  input  1  memory request accepted
- mem_size  input  3  request size code; bytes = 1 << mem_size (1..128)
- flop_inc  output  CNT_W  FLOPs in the emitted sample
- byte_inc  output  CNT_W  bytes in the emitted sample
- valid  output  1  one-cycle sample strobe
- busy  output  1  high while in ACCUM

Behaviour:
- Reset (async, rst=1): state=IDLE; flop_inc=0, byte_inc=0, valid=0, busy=0; accumulators=0; window counter wcnt=0. Release is synchronous to clk.
- Per-cycle increments, counted only in ACCUM with enable=1:
  - f = alu_issue ? popcount(alu_mask) * (alu_fma ? 2 : 1) : 0
  - b = (mem_valid & mem_ready) ? (1 << mem_size) : 0
  - mem_valid without mem_ready is never counted.
- All sums are computed one bit wider than CNT_W and saturate at all-ones; no wrap.
- valid defaults to 0 every cycle; it is never high for two consecutive cycles.
- flop_inc/byte_inc hold their value between strobes.
- IDLE:
  - busy=0; events are ignored.
  - enable=1 → ACCUM next cycle; accumulators and wcnt cleared.
- ACCUM, enable=1, wcnt < WINDOW-1:
  - acc += f/b (saturating); wcnt++.
- ACCUM, enable=1, wcnt == WINDOW-1 (boundary cycle):
  - flop_inc/byte_inc <= sat(acc + f/b); valid <= 1, so the strobe appears the cycle after the boundary.
  - acc <= 0; wcnt <= 0; stay in ACCUM.
  - The next cycle's events start the new window; no cycle is dropped or double-counted.
- ACCUM, enable=0:
  - Current-cycle events are not counted; next state is IDLE.
  - If wcnt != 0: flop_inc/byte_inc <= acc, valid <= 1 (partial-window flush).
  - If wcnt == 0: no strobe, outputs unchanged.
- Latency: sample strobe is exactly 1 cycle after the last counted cycle.
- A strobe and enable deassertion can coincide; deassertion only affects the cycle in which enable is sampled low.
- Reset mid-window discards the partial window with no flush strobe.

Optional Feature:
- Macro: PERF_OVF_STICKY_EN.
- Defined:
  - Adds output ovf (1 bit), reset value 0.
  - Set when any accumulator or output saturation occurs.
  - Cleared by rst and on the IDLE→ACCUM transition only.
- Undefined:
  - Port is absent; saturation is silent.

Test Plan:
- LANES=32, WINDOW=4: enable held high; alu_issue=1, mask=FFFF_FFFF, fma=0 every cycle → first valid 5 cycles after IDLE→ACCUM entry, flop_inc=128, byte_inc=0, then repeating every 4 cycles with identical values.
- WINDOW=4: fma=1, mask=0000_000F, issue every cycle; mem_valid=1, mem_ready toggling 1,0,1,0, mem_size=6 → each strobe flop_inc=32, byte_inc=128.
- WINDOW=8: enable dropped after 3 counted cycles of mask=0000_00FF (fma=0) → one strobe next cycle with flop_inc=24; busy=0 from that cycle; no further strobes.
- WINDOW=4: enable dropped the cycle after a boundary (wcnt=0) → no extra strobe; re-enable → counts restart from 0 (ovf cleared if compiled in).
- CNT_W=8, WINDOW=8, LANES=32: fma=1, full mask every cycle (64 FLOPs/cycle) → flop_inc=255, no wrap; ovf=1 with PERF_OVF_STICKY_EN.
- rst pulsed mid-window while outputs hold 128 → valid=0, flop_inc=0, byte_inc=0, busy=0 immediately (asynchronous); no strobe after release until enable is re-sampled high.

Source files
------------

// File: rtl/perf_sample_reporter.sv
// perf_sample_reporter
// Counts SIMD FLOPs and accepted memory bytes over a fixed window of
// counted cycles and emits one registered sample per window. Dropping
// enable flushes a partial window, if any cycles were counted.
// Optional build macro: PERF_OVF_STICKY_EN adds a sticky saturation flag (ovf).
//
// Memory handshake: a request transfers on a cycle where mem_valid and
// mem_ready are both high; only then are its bytes (1 << mem_size) counted.
// valid is a one-cycle strobe with no back-pressure; flop_inc/byte_inc
// hold their value between strobes.
module perf_sample_reporter #(
    parameter int LANES  = 32,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             alu_issue,
    input  logic [LANES-1:0] alu_mask,
    input  logic             alu_fma,
    input  logic             mem_valid,
    input  logic             mem_ready,
    input  logic [2:0]       mem_size,
    output logic [CNT_W-1:0] flop_inc,
    output logic [CNT_W-1:0] byte_inc,
    output logic             valid,
    output logic             busy,
`ifdef PERF_OVF_STICKY_EN
    output logic             ovf,
`endif
    output logic             state_dbg
);

    // Internal sum width: one bit above CNT_W, and at least wide enough
    // that a per-cycle increment plus a full accumulator cannot wrap.
    localparam int XW  = (CNT_W >= 16) ? CNT_W + 1 : 17;
    localparam int WCW = $clog2(WINDOW);
    localparam logic [WCW-1:0] WLAST   = WCW'(WINDOW - 1);
    localparam logic [XW-1:0]  SAT_MAX = {{(XW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] acc_flop, acc_byte;
    logic [WCW-1:0]   wcnt;
    logic [XW-1:0]    popcnt, f_raw, b_raw, f_sum_w, b_sum_w;
    logic [CNT_W-1:0] f_sum, b_sum;
    logic             f_sat, b_sat;
    logic             start, count_en, flush;

    // Per-cycle increments and saturating window sums.
    always_comb begin
        popcnt = '0;
        for (int i = 0; i < LANES; i++) begin
            popcnt = popcnt + XW'(alu_mask[i]);
        end
        f_raw   = alu_issue ? (alu_fma ? (popcnt << 1) : popcnt) : '0;
        b_raw   = (mem_valid && mem_ready) ? (XW'(1) << mem_size) : '0;
        f_sum_w = XW'(acc_flop) + f_raw;
        b_sum_w = XW'(acc_byte) + b_raw;
        f_sat   = (f_sum_w > SAT_MAX);
        b_sat   = (b_sum_w > SAT_MAX);
        f_sum   = f_sat ? '1 : f_sum_w[CNT_W-1:0];
        b_sum   = b_sat ? '1 : b_sum_w[CNT_W-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        count_en  = 1'b0;
        flush     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_ACCUM;
                    start     = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (enable) begin
                    count_en = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    flush     = (wcnt != '0);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_ACCUM);
    assign state_dbg = state;

    // Accumulators, window counter and registered sample outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_flop <= '0;
            acc_byte <= '0;
            wcnt     <= '0;
            flop_inc <= '0;
            byte_inc <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                acc_flop <= '0;
                acc_byte <= '0;
                wcnt     <= '0;
            end
            if (count_en) begin
                if (wcnt == WLAST) begin
                    // Boundary cycle: its own events close this window.
                    flop_inc <= f_sum;
                    byte_inc <= b_sum;
                    valid    <= 1'b1;
                    acc_flop <= '0;
                    acc_byte <= '0;
                    wcnt     <= '0;
                end else begin
                    acc_flop <= f_sum;
                    acc_byte <= b_sum;
                    wcnt     <= wcnt + 1'b1;
                end
            end
            if (flush) begin
                flop_inc <= acc_flop;
                byte_inc <= acc_byte;
                valid    <= 1'b1;
            end
        end
    end

`ifdef PERF_OVF_STICKY_EN
    // Sticky saturation flag, cleared only by reset and on window-run start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            ovf <= 1'b0;
        else if (start)                     ovf <= 1'b0;
        else if (count_en && (f_sat || b_sat)) ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_perf_sample_reporter.sv
// Directed bench for perf_sample_reporter: two instances share stimulus,
// one with WINDOW=4/CNT_W=32 and one with WINDOW=8/CNT_W=8.
module tb_perf_sample_reporter;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        alu_issue;
    logic [31:0] alu_mask;
    logic        alu_fma;
    logic        mem_valid;
    logic        mem_ready;
    logic [2:0]  mem_size;

    logic [31:0] u4_flop, u4_byte;
    logic        u4_valid, u4_busy, u4_state;
    logic [7:0]  u8_flop, u8_byte;
    logic        u8_valid, u8_busy, u8_state;
`ifdef PERF_OVF_STICKY_EN
    logic        u4_ovf, u8_ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    perf_sample_reporter #(.LANES(32), .WINDOW(4), .CNT_W(32)) u4 (
        .clk(clk), .rst(rst), .enable(enable),
        .alu_issue(alu_issue), .alu_mask(alu_mask), .alu_fma(alu_fma),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_size(mem_size),
        .flop_inc(u4_flop), .byte_inc(u4_byte), .valid(u4_valid), .busy(u4_busy),
`ifdef PERF_OVF_STICKY_EN
        .ovf(u4_ovf),
`endif
        .state_dbg(u4_state)
    );

    perf_sample_reporter #(.LANES(32), .WINDOW(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .enable(enable),
        .alu_issue(alu_issue), .alu_mask(alu_mask), .alu_fma(alu_fma),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_size(mem_size),
        .flop_inc(u8_flop), .byte_inc(u8_byte), .valid(u8_valid), .busy(u8_busy),
`ifdef PERF_OVF_STICKY_EN
        .ovf(u8_ovf),
`endif
        .state_dbg(u8_state)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Advance n clocks; outputs are sampled 1ns after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; alu_issue = 1'b0; alu_mask = '0; alu_fma = 1'b0;
        mem_valid = 1'b0; mem_ready = 1'b0; mem_size = 3'd0;
        #3;
        check("rst_valid", 32'(u4_valid), 32'd0);
        check("rst_flop",  u4_flop, 32'd0);
        check("rst_byte",  u4_byte, 32'd0);
        check("rst_busy",  32'(u4_busy), 32'd0);
        check("rst_u8_flop", 32'(u8_flop), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        check("idle_busy", 32'(u4_busy), 32'd0);

        // Full mask, no FMA: 32 FLOPs per counted cycle.
        enable = 1'b1; alu_issue = 1'b1; alu_mask = 32'hFFFF_FFFF; alu_fma = 1'b0;
        tick(1);                                   // IDLE -> ACCUM
        check("a_busy", 32'(u4_busy), 32'd1);
        check("a_valid_entry", 32'(u4_valid), 32'd0);
        tick(3);
        check("a_valid_early", 32'(u4_valid), 32'd0);
        tick(1);                                   // 4th counted cycle closes window
        check("a_valid1", 32'(u4_valid), 32'd1);
        check("a_flop1",  u4_flop, 32'd128);
        check("a_byte1",  u4_byte, 32'd0);
        check("a_u8_quiet", 32'(u8_valid), 32'd0);
        tick(1);
        check("a_strobe_1cyc", 32'(u4_valid), 32'd0);
        check("a_hold", u4_flop, 32'd128);
        tick(3);
        check("a_valid2", 32'(u4_valid), 32'd1);
        check("a_flop2",  u4_flop, 32'd128);
        // 8 cycles x 32 = 256 saturates the 8-bit instance.
        check("sat_u8_valid", 32'(u8_valid), 32'd1);
        check("sat_u8_flop",  32'(u8_flop), 32'd255);

        // FMA on 4 lanes (8 FLOPs) and 64-byte requests every other cycle.
        alu_fma = 1'b1; alu_mask = 32'h0000_000F; mem_valid = 1'b1; mem_size = 3'd6;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i % 2 == 0);
            tick(1);
            if (i == 3) begin
                check("b_valid1", 32'(u4_valid), 32'd1);
                check("b_flop1",  u4_flop, 32'd32);
                check("b_byte1",  u4_byte, 32'd128);
            end
        end
        check("b_valid2", 32'(u4_valid), 32'd1);
        check("b_flop2",  u4_flop, 32'd32);
        check("b_byte2",  u4_byte, 32'd128);
        check("b_u8_flop", 32'(u8_flop), 32'd64);
        check("b_u8_byte_sat", 32'(u8_byte), 32'd255);
        mem_valid = 1'b0; mem_ready = 1'b0;

        // Three counted cycles of 8 FLOPs, then enable drops: partial flush.
        alu_fma = 1'b0; alu_mask = 32'h0000_00FF;
        tick(3);
        enable = 1'b0;
        tick(1);
        check("c_u8_valid", 32'(u8_valid), 32'd1);
        check("c_u8_flop",  32'(u8_flop), 32'd24);
        check("c_u8_busy",  32'(u8_busy), 32'd0);
        check("c_u4_flop",  u4_flop, 32'd24);
        tick(1);
        check("c_no_more", 32'(u8_valid), 32'd0);
        check("c_hold", 32'(u8_flop), 32'd24);

        // Re-enable, complete a window, drop enable right after the boundary.
        enable = 1'b1; alu_mask = 32'hFFFF_FFFF;
        tick(5);
        check("d_valid", 32'(u4_valid), 32'd1);
        check("d_flop",  u4_flop, 32'd128);
        enable = 1'b0;
        tick(1);
        check("d_no_flush", 32'(u4_valid), 32'd0);
        check("d_busy", 32'(u4_busy), 32'd0);
        check("d_u8_flush", 32'(u8_valid), 32'd1);
        check("d_u8_flop",  32'(u8_flop), 32'd128);
        tick(1);
        check("d_quiet", 32'(u8_valid), 32'd0);

        // Restart counting with one lane: counts begin again from zero.
        enable = 1'b1; alu_mask = 32'h0000_0001;
        tick(1);
`ifdef PERF_OVF_STICKY_EN
        check("d_ovf_clr", 32'(u8_ovf), 32'd0);
`endif
        tick(4);
        check("d_restart", u4_flop, 32'd4);
        check("d_restart_v", 32'(u4_valid), 32'd1);
        alu_mask = 32'hFFFF_FFFF;
        tick(4);
        check("e_flop", u4_flop, 32'd128);
        check("e_u8_flop", 32'(u8_flop), 32'd132);
        tick(2);

        // Asynchronous reset mid-window.
        #2 rst = 1'b1;
        #1;
        check("e_rst_valid", 32'(u4_valid), 32'd0);
        check("e_rst_flop",  u4_flop, 32'd0);
        check("e_rst_byte",  u4_byte, 32'd0);
        check("e_rst_busy",  32'(u4_busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        check("e_post_valid", 32'(u4_valid), 32'd0);
        check("e_post_busy",  32'(u4_busy), 32'd1);
        tick(3);
        check("e_post_quiet", 32'(u4_valid), 32'd0);
        tick(1);
        check("e_post_valid2", 32'(u4_valid), 32'd1);
        check("e_post_flop",   u4_flop, 32'd128);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
